// File: rtl/hpdcache_sram_tiled.sv
// Tiled single-port SRAM: ROWS x COLS grid of macro tiles with
// post-reset zero fill, 1-cycle read strobe and out-of-range handling.
// Ports: clk, rst_n (sync, active low), cs/we/addr/wdata request,
// rdata/rvalid read response, ready = initialised and accepting.
module fakeram7_256x256 (
  output logic [255:0] rd_out,
  input  logic [7:0]   addr_in,
  input  logic         we_in,
  input  logic [255:0] wd_in,
  input  logic [255:0] w_mask_in,
  input  logic         clk,
  input  logic         ce_in
);
  logic [255:0] mem [256];

  always_ff @(posedge clk) begin
    if (ce_in) begin
      if (we_in) begin
        mem[addr_in] <= (mem[addr_in] & ~w_mask_in)
                      | (wd_in & w_mask_in);
      end else begin
        rd_out <= mem[addr_in];
      end
    end
  end
endmodule

module hpdcache_sram_1rw #(
  parameter int unsigned ADDR_SIZE = 8,
  parameter int unsigned DATA_SIZE = 64
) (
  input  logic                 clk,
  input  logic                 cs,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [DATA_SIZE-1:0] wdata,
  output logic [DATA_SIZE-1:0] rdata
);
  logic [DATA_SIZE-1:0] mem [2**ADDR_SIZE];

  always_ff @(posedge clk) begin
    if (cs) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end
endmodule

module hpdcache_sram_tiled #(
  parameter int unsigned ADDR_SIZE       = 8,
  parameter int unsigned DATA_SIZE       = 256,
  parameter int unsigned DEPTH           = 2**ADDR_SIZE,
  parameter int unsigned MACRO_ADDR_SIZE = 8,
  parameter int unsigned MACRO_DATA_SIZE = 256,
  parameter bit          INIT_ON_RESET   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cs,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [DATA_SIZE-1:0] wdata,
  output logic [DATA_SIZE-1:0] rdata,
  output logic                 rvalid,
  output logic                 ready
);
  localparam int unsigned MD   = 2**MACRO_ADDR_SIZE;
  localparam int unsigned MW   = MACRO_DATA_SIZE;
  localparam int unsigned COLS = (DATA_SIZE + MW - 1) / MW;
  localparam int unsigned ROWS = (DEPTH + MD - 1) / MD;
  localparam int unsigned RSEL_W =
    (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned PW   = COLS * MW;
  localparam int unsigned MA   = MACRO_ADDR_SIZE;

  localparam logic [ADDR_SIZE:0] DEPTH_L = DEPTH[ADDR_SIZE:0];
  localparam logic [MA-1:0] CNT_LAST = MA'(MD - 1);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]        state, state_d;
  logic [MA-1:0]     init_cnt;
  logic              ready_q;
  logic              rvalid_q;
  logic [RSEL_W-1:0] rsel_q;
  logic              oor_q;

  logic                 init;
  logic                 acc;
  logic                 oor;
  logic [ADDR_SIZE-1:0] row_sel;
  logic [MA-1:0]        t_addr;
  logic                 t_we;
  logic [PW-1:0]        t_wd;
  logic [ROWS-1:0]      t_cs;
  logic [ROWS-1:0][PW-1:0] t_rd;
  logic [PW-1:0]        rsel_data;

  assign init    = (state == ST_INIT);
  assign acc     = cs & ready_q;
  assign oor     = ({1'b0, addr} >= DEPTH_L);
  assign row_sel = addr >> MACRO_ADDR_SIZE;

  // During fill every tile is written with zero at init_cnt.
  assign t_addr = init ? init_cnt : addr[MA-1:0];
  assign t_we   = init | we;
  assign t_wd   = init ? '0 : PW'(wdata);

  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      t_cs[r] = init |
        (acc & ~oor & (row_sel == ADDR_SIZE'(r)));
    end
  end

  always_comb begin
    state_d = state;
    if (init && init_cnt == CNT_LAST) begin
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= INIT_ON_RESET ? ST_INIT : ST_RUN;
      init_cnt <= '0;
      ready_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rsel_q   <= '0;
      oor_q    <= 1'b0;
    end else begin
      state    <= state_d;
      ready_q  <= (state_d == ST_RUN);
      rvalid_q <= acc & ~we;
      if (init) begin
        init_cnt <= init_cnt + MA'(1);
      end
      if (acc && !we) begin
        rsel_q <= RSEL_W'(row_sel);
        oor_q  <= oor;
      end
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      if (MACRO_ADDR_SIZE == 8 && MACRO_DATA_SIZE == 256)
      begin : g_fr
        fakeram7_256x256 u_tile (
          .rd_out    (t_rd[r][c*MW +: MW]),
          .addr_in   (t_addr[7:0]),
          .we_in     (t_we),
          .wd_in     (t_wd[c*MW +: MW]),
          .w_mask_in ({256{1'b1}}),
          .clk       (clk),
          .ce_in     (t_cs[r])
        );
      end else begin : g_gen
        hpdcache_sram_1rw #(
          .ADDR_SIZE (MACRO_ADDR_SIZE),
          .DATA_SIZE (MACRO_DATA_SIZE)
        ) u_tile (
          .clk   (clk),
          .cs    (t_cs[r]),
          .we    (t_we),
          .addr  (t_addr),
          .wdata (t_wd[c*MW +: MW]),
          .rdata (t_rd[r][c*MW +: MW])
        );
      end
    end
  end

  always_comb begin
    rsel_data = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (rsel_q == RSEL_W'(r)) begin
        rsel_data = t_rd[r];
      end
    end
  end

  assign rdata  = oor_q ? '0 : rsel_data[DATA_SIZE-1:0];
  assign rvalid = rvalid_q;
  assign ready  = ready_q;
endmodule

// File: tb/tb_hpdcache_sram_tiled.sv
// Bench for hpdcache_sram_tiled: default geometry plus
// 4x2 and DEPTH=600 tilings driven by a shared vector table.
module tb_hpdcache_sram_tiled;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         a_cs, a_we;
  logic [7:0]   a_addr;
  logic [255:0] a_wdata, a_rdata;
  logic         a_rvalid, a_ready;

  logic         b_cs, b_we;
  logic [9:0]   b_addr;
  logic [299:0] b_wdata, b1_rdata, b2_rdata;
  logic         b1_rvalid, b1_ready, b2_rvalid, b2_ready;

  hpdcache_sram_tiled u_a (
    .clk(clk), .rst_n(rst_n), .cs(a_cs), .we(a_we),
    .addr(a_addr), .wdata(a_wdata), .rdata(a_rdata),
    .rvalid(a_rvalid), .ready(a_ready)
  );

  hpdcache_sram_tiled #(
    .ADDR_SIZE(10), .DATA_SIZE(300), .DEPTH(1024)
  ) u_b1 (
    .clk(clk), .rst_n(rst_n), .cs(b_cs), .we(b_we),
    .addr(b_addr), .wdata(b_wdata), .rdata(b1_rdata),
    .rvalid(b1_rvalid), .ready(b1_ready)
  );

  hpdcache_sram_tiled #(
    .ADDR_SIZE(10), .DATA_SIZE(300), .DEPTH(600)
  ) u_b2 (
    .clk(clk), .rst_n(rst_n), .cs(b_cs), .we(b_we),
    .addr(b_addr), .wdata(b_wdata), .rdata(b2_rdata),
    .rvalid(b2_rvalid), .ready(b2_ready)
  );

  typedef struct {
    logic         cs;
    logic         we;
    logic [9:0]   addr;
    logic [299:0] wd;
    logic         v1;
    logic [299:0] d1;
    logic         v2;
    logic [299:0] d2;
  } vec_t;

  localparam int NV = 17;
  vec_t tbl [NV];

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm,
                     input logic [299:0] act,
                     input logic [299:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s act=%h exp=%h", nm, act, exp);
  endtask

  function automatic logic [299:0] mk(input int k);
    return {44'h3FF_0000_00A5 + 44'(k),
            {8{32'hA5A5_0000 + 32'(k)}}};
  endfunction

  function automatic vec_t v(input logic c, input logic w,
      input logic [9:0] ad, input logic [299:0] wd,
      input logic e1, input logic [299:0] x1,
      input logic e2, input logic [299:0] x2);
    vec_t t;
    t.cs = c; t.we = w; t.addr = ad; t.wd = wd;
    t.v1 = e1; t.d1 = x1; t.v2 = e2; t.d2 = x2;
    return t;
  endfunction

  task automatic a_op(input logic w, input logic [7:0] ad,
                      input logic [255:0] wd);
    a_cs = 1'b1; a_we = w; a_addr = ad; a_wdata = wd;
    @(posedge clk); #1;
    a_cs = 1'b0;
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (!a_ready && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_cycles"}, 300'(n), 300'd256);
    chk({nm, "_b1rdy"}, 300'(b1_ready), 300'd1);
    chk({nm, "_b2rdy"}, 300'(b2_ready), 300'd1);
  endtask

  initial begin
    int n;
    tbl[0]  = v(1, 1, 10'h000, mk(0), 0, 0, 0, 0);
    tbl[1]  = v(1, 1, 10'h155, mk(1), 0, 0, 0, 0);
    tbl[2]  = v(1, 1, 10'h2AA, mk(2), 0, 0, 0, 0);
    tbl[3]  = v(1, 1, 10'h3FF, mk(3), 0, 0, 0, 0);
    tbl[4]  = v(1, 0, 10'h000, 0, 1, mk(0), 1, mk(0));
    tbl[5]  = v(1, 0, 10'h155, 0, 1, mk(1), 1, mk(1));
    tbl[6]  = v(1, 0, 10'h2AA, 0, 1, mk(2), 1, 0);
    tbl[7]  = v(1, 0, 10'h3FF, 0, 1, mk(3), 1, 0);
    tbl[8]  = v(1, 1, 10'd5, 300'hAA, 0, 0, 0, 0);
    tbl[9]  = v(1, 0, 10'd5, 0, 1, 300'hAA, 1, 300'hAA);
    tbl[10] = v(1, 0, 10'd261, 0, 1, 0, 1, 0);
    tbl[11] = v(1, 1, 10'd599, mk(4), 0, 0, 0, 0);
    tbl[12] = v(1, 0, 10'd599, 0, 1, mk(4), 1, mk(4));
    tbl[13] = v(1, 1, 10'd700, mk(5), 0, 0, 0, 0);
    tbl[14] = v(1, 0, 10'd700, 0, 1, mk(5), 1, 0);
    tbl[15] = v(0, 0, 10'd599, 0, 0, 0, 0, 0);
    tbl[16] = v(1, 0, 10'd1, 0, 1, 0, 1, 0);

    rst_n = 1'b0;
    a_cs = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_cs = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 300'(a_ready), 0);
    chk("rst_rvalid", 300'(a_rvalid), 0);
    chk("rst_b1ready", 300'(b1_ready), 0);

    rst_n = 1'b1;
    n = 0;
    while (!a_ready && n < 400) begin
      @(posedge clk); #1;
      n++;
      if (n == 10) begin
        a_cs = 1; a_we = 1; a_addr = 8'd3; a_wdata = 256'h55;
      end
      if (n == 11) a_cs = 0;
      if (n == 12) chk("init_no_rvalid", 300'(a_rvalid), 0);
    end
    chk("init_cycles", 300'(n), 300'd256);
    chk("init_b1rdy", 300'(b1_ready), 300'd1);
    chk("init_b2rdy", 300'(b2_ready), 300'd1);

    a_op(0, 8'h00, 0);
    chk("a_rd00_v", 300'(a_rvalid), 1);
    chk("a_rd00_d", 300'(a_rdata), 0);
    a_op(0, 8'hFF, 0);
    chk("a_rdFF_v", 300'(a_rvalid), 1);
    chk("a_rdFF_d", 300'(a_rdata), 0);
    a_op(0, 8'd3, 0);
    chk("a_rd3_ign", 300'(a_rdata), 0);
    a_op(1, 8'h10, 256'hAA);
    chk("a_wr_norv", 300'(a_rvalid), 0);
    a_op(0, 8'h10, 0);
    chk("a_rd10_v", 300'(a_rvalid), 1);
    chk("a_rd10_d", 300'(a_rdata), 300'hAA);
    @(posedge clk); #1;
    chk("a_idle_v", 300'(a_rvalid), 0);

    for (int i = 0; i < NV; i++) begin
      b_cs = tbl[i].cs; b_we = tbl[i].we;
      b_addr = tbl[i].addr; b_wdata = tbl[i].wd;
      @(posedge clk); #1;
      chk($sformatf("v%0d_rv1", i), 300'(b1_rvalid),
          300'(tbl[i].v1));
      chk($sformatf("v%0d_rv2", i), 300'(b2_rvalid),
          300'(tbl[i].v2));
      if (tbl[i].v1)
        chk($sformatf("v%0d_d1", i), b1_rdata, tbl[i].d1);
      if (tbl[i].v2)
        chk($sformatf("v%0d_d2", i), b2_rdata, tbl[i].d2);
    end
    b_cs = 0;

    b_cs = 1; b_we = 0; b_addr = 10'd5;
    rst_n = 1'b0;
    @(posedge clk); #1;
    b_cs = 0;
    chk("rst_rd_drop", 300'(b1_rvalid), 0);
    chk("rst_rd_rdy", 300'(b1_ready), 0);
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    chk("mid_init_rdy", 300'(a_ready), 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_ready("reinit");
    b_cs = 1; b_we = 0; b_addr = 10'd5;
    @(posedge clk); #1;
    b_cs = 0;
    chk("reinit_rd5_v", 300'(b1_rvalid), 1);
    chk("reinit_rd5_d", b1_rdata, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
